regfile: RTL and testbench
==========================

# regfile

General-purpose register file at the consuming end of the write-back path: it accepts the write (address, enable, data) registered by the MEM/WB pipeline stage and serves two independent read ports to the decode stage. Storage is 32 words of 32 bits; register 0 reads as zero and ignores writes. An optional same-cycle write-to-read bypass lets decode see a value in the cycle it is being written back.

## Interface
Parameters (from the shared defines, not module parameters):
- RegBus: 31:0, data word width.
- RegAddrBus: 4:0, register address width.
- RegNum: 32, number of registers.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset (rst == Enable), sampled on posedge clk.
- wreg_i  in  1  write enable from MEM/WB.
- rw_i  in  RegAddrBus  write address from MEM/WB.
- wdata_i  in  RegBus  write data from MEM/WB.
- re1_i  in  1  read-port-1 enable.
- raddr1_i  in  RegAddrBus  read-port-1 address.
- rdata1_o  out  RegBus  read-port-1 data.
- re2_i  in  1  read-port-2 enable.
- raddr2_i  in  RegAddrBus  read-port-2 address.
- rdata2_o  out  RegBus  read-port-2 data.

## Operation
- Write: on posedge clk with rst deasserted, if wreg_i == Enable and rw_i != 0, regs[rw_i] <= wdata_i. Writes to address 0 are discarded.
- Reset: on posedge clk with rst asserted, all 32 registers <= ZeroWord; any write presented in that cycle is dropped.
- Read port n (identical, independent), combinational, priority order:
  - rst asserted -> ZeroWord.
  - re_n deasserted -> ZeroWord.
  - raddr_n == 0 -> ZeroWord.
  - bypass hit (see Configuration) -> wdata_i.
  - otherwise -> regs[raddr_n].
- Both ports may read the same address, and both may match the write address in the same cycle; each resolves independently.
- No handshake; write and reads are accepted every cycle.

## Timing
- Write latency: data written on edge k is visible through storage from the cycle after edge k.
- Read latency: zero cycles (combinational from address/enable to data).
- Reset value: all registers 0; rdata1_o and rdata2_o are 0 while rst is high.
- Reset asserted mid-stream: storage clears on the first reset edge; writes pending in that cycle are lost; reads return 0 throughout reset.
- Reset deassertion: the first write is accepted on the first edge with rst low.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: bypass hit = wreg_i == Enable and rw_i == raddr_n and raddr_n != 0 and re_n == Enable; the port returns wdata_i in the same cycle as the write. This removes the WB-to-ID hazard.
- Undefined: no bypass; the port returns the old stored value during the write cycle and the new value from the next cycle. The pipeline must then stall or forward externally.

## Structure
- Shared defines file holds RegBus, RegAddrBus, RegNum, RegNumLog2, NOPRegAddr, ZeroWord, and Enable/Disable. No local redefinitions.
- Storage array and write logic live in this module.
- Sub-module regfile_rd_port is instantiated twice. It contains the enable/zero/bypass/array read mux for one port. The storage array word and the write-port signals are passed in, and the bypass is compiled under REGFILE_BYPASS_EN.

## Test plan
- Reset, then read all addresses on both ports with re=1 -> all 0. Hold rst high while writing 0xDEADBEEF to r5 -> r5 still reads 0 after reset.
- Write 0x12345678 to r0, then read r0 on both ports -> 0.
- Write 0xA5A5A5A5 to r7 at edge k. Port 1 reads r7 and port 2 reads r8 in the same cycle:
  - With bypass: port 1 = 0xA5A5A5A5.
  - Without bypass: port 1 = old value.
  - In the next cycle, port 1 = 0xA5A5A5A5 in both builds; port 2 = 0 throughout.
- Write r3 = 0x1, then read r3 on both ports with re1=1, re2=0 -> rdata1_o = 0x1, rdata2_o = 0.
- Back-to-back writes r31 = 0xFFFFFFFF, then r31 = 0x0, then r1 = 0x55 -> after the third edge, r31 = 0 and r1 = 0x55. Assert rst for one edge -> both read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defines for the general-purpose register file: word/address types,
// register count, the zero word and enable levels.
package regfile_pkg;

   localparam int REG_BUS_W    = 32;
   localparam int REG_NUM      = 32;
   localparam int REG_NUM_LOG2 = 5;

   typedef logic [REG_BUS_W-1:0]    reg_bus_t;
   typedef logic [REG_NUM_LOG2-1:0] reg_addr_t;

   localparam reg_addr_t NOP_REG_ADDR = '0;
   localparam reg_bus_t  ZERO_WORD    = '0;
   localparam logic      ENABLE       = 1'b1;
   localparam logic      DISABLE      = 1'b0;

   function automatic logic is_nop_addr(input reg_addr_t addr);
      return (addr == NOP_REG_ADDR);
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Write-back and decode-read signal bundle of the register file.
// The master is the pipeline side; the slave is the register file.
interface regfile_if;
   import regfile_pkg::*;

   logic      wreg_i;
   reg_addr_t rw_i;
   reg_bus_t  wdata_i;
   logic      re1_i;
   reg_addr_t raddr1_i;
   reg_bus_t  rdata1_o;
   logic      re2_i;
   reg_addr_t raddr2_i;
   reg_bus_t  rdata2_o;

   modport master (
      output wreg_i, rw_i, wdata_i,
      output re1_i, raddr1_i, re2_i, raddr2_i,
      input  rdata1_o, rdata2_o
   );

   modport slave (
      input  wreg_i, rw_i, wdata_i,
      input  re1_i, raddr1_i, re2_i, raddr2_i,
      output rdata1_o, rdata2_o
   );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: reset/enable/r0 gating, optional write-to-read
// bypass (REGFILE_BYPASS_EN), else the stored word.
module regfile_rd_port
   import regfile_pkg::*;
(
   input  logic      rst,
   input  logic      re,
   input  reg_addr_t raddr,
   input  reg_bus_t  word,
   input  logic      wreg,
   input  reg_addr_t rw,
   input  reg_bus_t  wdata,
   output reg_bus_t  rdata
);

`ifndef REGFILE_BYPASS_EN
   // Write-port inputs only feed the bypass; keep them visibly consumed.
   logic unused_wr;
   assign unused_wr = ^{wreg, rw, wdata};
`endif

   always_comb begin
      rdata = ZERO_WORD;
      if (rst == ENABLE || re == DISABLE || is_nop_addr(raddr)) begin
         rdata = ZERO_WORD;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wreg == ENABLE && rw == raddr) begin
         rdata = wdata;
      end
`endif
      else begin
         rdata = word;
      end
   end

endmodule

// File: rtl/regfile.sv
// 32x32 register file with one write port and two read ports; r0 is hardwired
// to zero. Same-cycle write-to-read bypass is built when REGFILE_BYPASS_EN is defined.
module regfile
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   regfile_if.slave  bus
);

   reg_bus_t regs [REG_NUM];
   reg_bus_t word1;
   reg_bus_t word2;

   // Reset wins over any write presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst == ENABLE) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs[i] <= ZERO_WORD;
         end
      end else if (bus.wreg_i == ENABLE && !is_nop_addr(bus.rw_i)) begin
         regs[bus.rw_i] <= bus.wdata_i;
      end
   end

   assign word1 = regs[bus.raddr1_i];
   assign word2 = regs[bus.raddr2_i];

   regfile_rd_port u_rd1 (
      .rst   (rst),
      .re    (bus.re1_i),
      .raddr (bus.raddr1_i),
      .word  (word1),
      .wreg  (bus.wreg_i),
      .rw    (bus.rw_i),
      .wdata (bus.wdata_i),
      .rdata (bus.rdata1_o)
   );

   regfile_rd_port u_rd2 (
      .rst   (rst),
      .re    (bus.re2_i),
      .raddr (bus.raddr2_i),
      .word  (word2),
      .wreg  (bus.wreg_i),
      .rw    (bus.rw_i),
      .wdata (bus.wdata_i),
      .rdata (bus.rdata2_o)
   );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations track REGFILE_BYPASS_EN.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   regfile_if bus ();

   regfile dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.wreg_i   = 1'b0;
      bus.rw_i     = 5'd0;
      bus.wdata_i  = 32'h0;
      bus.re1_i    = 1'b0;
      bus.raddr1_i = 5'd0;
      bus.re2_i    = 1'b0;
      bus.raddr2_i = 5'd0;
   endtask

   task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.wreg_i  = 1'b1;
      bus.rw_i    = addr;
      bus.wdata_i = data;
      @(posedge clk);
      #1;
      bus.wreg_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      bus.wreg_i   = 1'b1;
      bus.rw_i     = 5'd5;
      bus.wdata_i  = 32'hDEADBEEF;
      bus.re1_i    = 1'b1;
      bus.re2_i    = 1'b1;
      bus.raddr1_i = 5'd5;
      bus.raddr2_i = 5'd5;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h0 || bus.rdata2_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_read_during_rst got %h/%h exp 0/0", bus.rdata1_o, bus.rdata2_o);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.wreg_i = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus.raddr1_i = 5'(i);
         bus.raddr2_i = 5'(31 - i);
         #1;
         checks++;
         if (bus.rdata1_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_p1_r%0d got %h exp 00000000", i, bus.rdata1_o);
         end
         checks++;
         if (bus.rdata2_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_p2_r%0d got %h exp 00000000", 31 - i, bus.rdata2_o);
         end
      end
   endtask

   task automatic test_first_write_after_reset();
      do_write(5'd9, 32'h00000077);
      bus.re1_i    = 1'b1;
      bus.raddr1_i = 5'd9;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h00000077) begin
         errors++;
         $display("FAIL first_write_r9 got %h exp 00000077", bus.rdata1_o);
      end
   endtask

   task automatic test_r0();
      @(negedge clk);
      bus.wreg_i   = 1'b1;
      bus.rw_i     = 5'd0;
      bus.wdata_i  = 32'h12345678;
      bus.re1_i    = 1'b1;
      bus.re2_i    = 1'b1;
      bus.raddr1_i = 5'd0;
      bus.raddr2_i = 5'd0;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h0 || bus.rdata2_o !== 32'h0) begin
         errors++;
         $display("FAIL r0_during_write got %h/%h exp 0/0", bus.rdata1_o, bus.rdata2_o);
      end
      @(posedge clk);
      @(negedge clk);
      bus.wreg_i = 1'b0;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h0 || bus.rdata2_o !== 32'h0) begin
         errors++;
         $display("FAIL r0_after_write got %h/%h exp 0/0", bus.rdata1_o, bus.rdata2_o);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp1;
      do_write(5'd7, 32'h11111111);
      @(negedge clk);
      bus.wreg_i   = 1'b1;
      bus.rw_i     = 5'd7;
      bus.wdata_i  = 32'hA5A5A5A5;
      bus.re1_i    = 1'b1;
      bus.re2_i    = 1'b1;
      bus.raddr1_i = 5'd7;
      bus.raddr2_i = 5'd8;
      exp1 = BYPASS ? 32'hA5A5A5A5 : 32'h11111111;
      #1;
      checks++;
      if (bus.rdata1_o !== exp1) begin
         errors++;
         $display("FAIL bypass_p1_write_cycle got %h exp %h", bus.rdata1_o, exp1);
      end
      checks++;
      if (bus.rdata2_o !== 32'h0) begin
         errors++;
         $display("FAIL bypass_p2_r8_write_cycle got %h exp 00000000", bus.rdata2_o);
      end
      @(posedge clk);
      @(negedge clk);
      bus.wreg_i = 1'b0;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL bypass_p1_next_cycle got %h exp a5a5a5a5", bus.rdata1_o);
      end
      checks++;
      if (bus.rdata2_o !== 32'h0) begin
         errors++;
         $display("FAIL bypass_p2_r8_next_cycle got %h exp 00000000", bus.rdata2_o);
      end
      // a disabled port must not see the bypassed value
      @(negedge clk);
      bus.wreg_i   = 1'b1;
      bus.rw_i     = 5'd7;
      bus.wdata_i  = 32'h5A5A5A5A;
      bus.re1_i    = 1'b0;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h0) begin
         errors++;
         $display("FAIL bypass_p1_disabled got %h exp 00000000", bus.rdata1_o);
      end
      @(posedge clk);
      #1;
      bus.wreg_i = 1'b0;
   endtask

   task automatic test_port_enable();
      do_write(5'd3, 32'h00000001);
      @(negedge clk);
      bus.re1_i    = 1'b1;
      bus.re2_i    = 1'b0;
      bus.raddr1_i = 5'd3;
      bus.raddr2_i = 5'd3;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h00000001) begin
         errors++;
         $display("FAIL enable_p1_r3 got %h exp 00000001", bus.rdata1_o);
      end
      checks++;
      if (bus.rdata2_o !== 32'h0) begin
         errors++;
         $display("FAIL enable_p2_off got %h exp 00000000", bus.rdata2_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_mid;
      @(negedge clk);
      bus.re1_i    = 1'b1;
      bus.re2_i    = 1'b1;
      bus.raddr1_i = 5'd31;
      bus.raddr2_i = 5'd1;
      bus.wreg_i   = 1'b1;
      bus.rw_i     = 5'd31;
      bus.wdata_i  = 32'hFFFFFFFF;
      @(negedge clk);
      bus.rw_i     = 5'd31;
      bus.wdata_i  = 32'h00000000;
      exp_mid = BYPASS ? 32'h00000000 : 32'hFFFFFFFF;
      #1;
      checks++;
      if (bus.rdata1_o !== exp_mid) begin
         errors++;
         $display("FAIL b2b_r31_second_cycle got %h exp %h", bus.rdata1_o, exp_mid);
      end
      @(negedge clk);
      bus.rw_i     = 5'd1;
      bus.wdata_i  = 32'h00000055;
      @(negedge clk);
      bus.wreg_i   = 1'b0;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h0) begin
         errors++;
         $display("FAIL b2b_r31_final got %h exp 00000000", bus.rdata1_o);
      end
      checks++;
      if (bus.rdata2_o !== 32'h00000055) begin
         errors++;
         $display("FAIL b2b_r1_final got %h exp 00000055", bus.rdata2_o);
      end
   endtask

   task automatic test_mid_reset();
      do_write(5'd31, 32'hCAFEF00D);
      @(negedge clk);
      rst          = 1'b1;
      bus.wreg_i   = 1'b1;
      bus.rw_i     = 5'd1;
      bus.wdata_i  = 32'h00000099;
      bus.re1_i    = 1'b1;
      bus.re2_i    = 1'b1;
      bus.raddr1_i = 5'd31;
      bus.raddr2_i = 5'd1;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h0 || bus.rdata2_o !== 32'h0) begin
         errors++;
         $display("FAIL midrst_during got %h/%h exp 0/0", bus.rdata1_o, bus.rdata2_o);
      end
      @(negedge clk);
      rst        = 1'b0;
      bus.wreg_i = 1'b0;
      #1;
      checks++;
      if (bus.rdata1_o !== 32'h0) begin
         errors++;
         $display("FAIL midrst_r31 got %h exp 00000000", bus.rdata1_o);
      end
      checks++;
      if (bus.rdata2_o !== 32'h0) begin
         errors++;
         $display("FAIL midrst_r1 got %h exp 00000000", bus.rdata2_o);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_first_write_after_reset();
      test_r0();
      test_bypass();
      test_port_enable();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
